// File: rtl/itch_add_order_mpid_tx.sv
// itch_add_order_mpid_tx
// Serializes an ITCH Add Order with Participant ID message (type 'F', 0x46)
// into six little-endian 64-bit words on a valid/ready stream.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   sendAddOrderWithMPID     start request; fields captured when not busy
//   timeStamp .. participantID  message fields (copied bit-exact)
//   sideError                one-cycle pulse on a rejected side value
//                            (only with ITCH_ADD_MPID_SIDE_CHECK_EN)
//   busy                     capture until the last-word handshake
//   dataOut/dataValid/dataReady/dataLast/dataKeep/wordIndex  word stream
//
// Optional feature macro: ITCH_ADD_MPID_SIDE_CHECK_EN
//   Defined: side must be 'B' (0x42) or 'S' (0x53), otherwise the request
//   is dropped and sideError pulses. Undefined: any side is serialized.
//
// All outputs come straight from flops; the next-output logic looks ahead
// at the next state so that words appear the cycle after capture/accept.

module itch_add_order_mpid_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic        sendAddOrderWithMPID,
  input  logic [31:0] timeStamp,
  input  logic [63:0] orderID,
  input  logic [31:0] orderBookID,
  input  logic [7:0]  side,
  input  logic [31:0] orderBookPosition,
  input  logic [63:0] quantity,
  input  logic [31:0] price,
  input  logic [15:0] orderAttributes,
  input  logic [7:0]  lotType,
  input  logic [55:0] participantID,
`ifdef ITCH_ADD_MPID_SIDE_CHECK_EN
  output logic        sideError,
`endif
  output logic        busy,
  output logic [63:0] dataOut,
  output logic        dataValid,
  input  logic        dataReady,
  output logic        dataLast,
  output logic [7:0]  dataKeep,
  output logic [2:0]  wordIndex
);

  localparam int unsigned WORD_W = 64;
  localparam int unsigned KEEP_W = 8;
  localparam int unsigned IDX_W  = 3;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(5);
  localparam logic [KEEP_W-1:0] KEEP_FULL = 8'hFF;
  localparam logic [KEEP_W-1:0] KEEP_LAST = 8'h3F;
  localparam logic [7:0]        MSG_TYPE  = 8'h46;

  typedef enum logic {IDLE, SEND} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               capture;
  logic               side_ok;

  // Holding registers for the captured message
  logic [31:0] ts_q,   ts_d;
  logic [63:0] oid_q,  oid_d;
  logic [31:0] obid_q, obid_d;
  logic [7:0]  side_q, side_d;
  logic [31:0] pos_q,  pos_d;
  logic [63:0] qty_q,  qty_d;
  logic [31:0] prc_q,  prc_d;
  logic [15:0] attr_q, attr_d;
  logic [7:0]  lot_q,  lot_d;
  logic [55:0] pid_q,  pid_d;

  // Registered output stage
  logic              valid_q, valid_d;
  logic [WORD_W-1:0] data_q,  data_d;
  logic              last_q,  last_d;
  logic [KEEP_W-1:0] keep_q,  keep_d;

  // Side acceptance at capture time
  always_comb begin
`ifdef ITCH_ADD_MPID_SIDE_CHECK_EN
    side_ok = (side == 8'h42) || (side == 8'h53);
`else
    side_ok = 1'b1;
`endif
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (sendAddOrderWithMPID && side_ok) begin
          capture = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (dataReady) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Holding register next values; stable for the whole message
  always_comb begin
    ts_d   = capture ? timeStamp         : ts_q;
    oid_d  = capture ? orderID           : oid_q;
    obid_d = capture ? orderBookID       : obid_q;
    side_d = capture ? side              : side_q;
    pos_d  = capture ? orderBookPosition : pos_q;
    qty_d  = capture ? quantity          : qty_q;
    prc_d  = capture ? price             : prc_q;
    attr_d = capture ? orderAttributes   : attr_q;
    lot_d  = capture ? lotType           : lot_q;
    pid_d  = capture ? participantID     : pid_q;
  end

  // Output decode from next state, so registered outputs line up with state_q
  always_comb begin
    valid_d = 1'b0;
    data_d  = '0;
    last_d  = 1'b0;
    keep_d  = '0;
    if (state_d == SEND) begin
      valid_d = 1'b1;
      last_d  = (idx_d == LAST_IDX);
      keep_d  = (idx_d == LAST_IDX) ? KEEP_LAST : KEEP_FULL;
      case (idx_d)
        IDX_W'(0): data_d = {oid_d[7:0], ts_d, 16'h0000, MSG_TYPE};
        IDX_W'(1): data_d = {obid_d[7:0], oid_d[63:8]};
        IDX_W'(2): data_d = {pos_d, side_d, obid_d[31:8]};
        IDX_W'(3): data_d = qty_d;
        IDX_W'(4): data_d = {pid_d[7:0], lot_d, attr_d, prc_d};
        IDX_W'(5): data_d = {16'h0000, pid_d[55:8]};
        default:   data_d = '0;
      endcase
    end
  end

  // State, holding and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ts_q    <= '0;
      oid_q   <= '0;
      obid_q  <= '0;
      side_q  <= '0;
      pos_q   <= '0;
      qty_q   <= '0;
      prc_q   <= '0;
      attr_q  <= '0;
      lot_q   <= '0;
      pid_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      keep_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ts_q    <= ts_d;
      oid_q   <= oid_d;
      obid_q  <= obid_d;
      side_q  <= side_d;
      pos_q   <= pos_d;
      qty_q   <= qty_d;
      prc_q   <= prc_d;
      attr_q  <= attr_d;
      lot_q   <= lot_d;
      pid_q   <= pid_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      keep_q  <= keep_d;
    end
  end

`ifdef ITCH_ADD_MPID_SIDE_CHECK_EN
  logic side_err_q, side_err_d;

  // Pulse for one cycle when an idle-time request carries a bad side
  always_comb begin
    side_err_d = (state_q == IDLE) && sendAddOrderWithMPID && !side_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      side_err_q <= 1'b0;
    end else begin
      side_err_q <= side_err_d;
    end
  end

  assign sideError = side_err_q;
`endif

  assign busy      = valid_q;
  assign dataValid = valid_q;
  assign dataOut   = data_q;
  assign dataLast  = last_q;
  assign dataKeep  = keep_q;
  assign wordIndex = idx_q;

endmodule

// File: tb/tb_itch_add_order_mpid_tx.sv
// Directed bench for itch_add_order_mpid_tx. Inputs are driven and outputs
// sampled on the falling edge; expected words are hand-computed constants.

module tb_itch_add_order_mpid_tx;

  logic        clk;
  logic        rst;
  logic        sendAddOrderWithMPID;
  logic [31:0] timeStamp;
  logic [63:0] orderID;
  logic [31:0] orderBookID;
  logic [7:0]  side;
  logic [31:0] orderBookPosition;
  logic [63:0] quantity;
  logic [31:0] price;
  logic [15:0] orderAttributes;
  logic [7:0]  lotType;
  logic [55:0] participantID;
  logic        busy;
  logic [63:0] dataOut;
  logic        dataValid;
  logic        dataReady;
  logic        dataLast;
  logic [7:0]  dataKeep;
  logic [2:0]  wordIndex;
`ifdef ITCH_ADD_MPID_SIDE_CHECK_EN
  logic        sideError;
`endif

  int checks = 0;
  int errors = 0;

  // Message A (test-plan basic message) and message B
  localparam logic [63:0] EXP_A [6] = '{
    64'h0811223344000046, 64'hDD01020304050607, 64'h0000000742AABBCC,
    64'h00000000000003E8, 64'h4D01000100989680, 64'h00004D4D4D4D4D4D};
  localparam logic [63:0] EXP_B [6] = '{
    64'h88DEADBEEF000046, 64'h0411223344556677, 64'h0A0B0C0D53010203,
    64'hFFEEDDCCBBAA9988, 64'h4702ABCD12345678, 64'h0000414243444546};

  itch_add_order_mpid_tx dut (
    .clk                  (clk),
    .rst                  (rst),
    .sendAddOrderWithMPID (sendAddOrderWithMPID),
    .timeStamp            (timeStamp),
    .orderID              (orderID),
    .orderBookID          (orderBookID),
    .side                 (side),
    .orderBookPosition    (orderBookPosition),
    .quantity             (quantity),
    .price                (price),
    .orderAttributes      (orderAttributes),
    .lotType              (lotType),
    .participantID        (participantID),
`ifdef ITCH_ADD_MPID_SIDE_CHECK_EN
    .sideError            (sideError),
`endif
    .busy                 (busy),
    .dataOut              (dataOut),
    .dataValid            (dataValid),
    .dataReady            (dataReady),
    .dataLast             (dataLast),
    .dataKeep             (dataKeep),
    .wordIndex            (wordIndex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_fields_a(input logic [7:0] s);
    timeStamp         = 32'h11223344;
    orderID           = 64'h0102030405060708;
    orderBookID       = 32'hAABBCCDD;
    side              = s;
    orderBookPosition = 32'd7;
    quantity          = 64'd1000;
    price             = 32'h00989680;
    orderAttributes   = 16'h0001;
    lotType           = 8'h01;
    participantID     = 56'h4D4D4D4D4D4D4D;
  endtask

  task automatic set_fields_b();
    timeStamp         = 32'hDEADBEEF;
    orderID           = 64'h1122334455667788;
    orderBookID       = 32'h01020304;
    side              = 8'h53;
    orderBookPosition = 32'h0A0B0C0D;
    quantity          = 64'hFFEEDDCCBBAA9988;
    price             = 32'h12345678;
    orderAttributes   = 16'hABCD;
    lotType           = 8'h02;
    participantID     = 56'h41424344454647;
  endtask

  // Called at a falling edge while idle; returns at the falling edge after capture
  task automatic start_msg();
    sendAddOrderWithMPID = 1'b1;
    @(negedge clk);
    sendAddOrderWithMPID = 1'b0;
  endtask

  task automatic test_reset();
    rst                  = 1'b1;
    sendAddOrderWithMPID = 1'($urandom());
    dataReady            = 1'($urandom());
    timeStamp            = $urandom();
    orderID              = {$urandom(), $urandom()};
    orderBookID          = $urandom();
    side                 = 8'($urandom());
    orderBookPosition    = $urandom();
    quantity             = {$urandom(), $urandom()};
    price                = $urandom();
    orderAttributes      = 16'($urandom());
    lotType              = 8'($urandom());
    participantID        = 56'({$urandom(), $urandom()});
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({busy, dataValid, dataLast, dataKeep, wordIndex, dataOut} !== 77'd0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got busy=%b valid=%b last=%b keep=%h idx=%0d data=%h, expected all 0",
                 c, busy, dataValid, dataLast, dataKeep, wordIndex, dataOut);
      end
`ifdef ITCH_ADD_MPID_SIDE_CHECK_EN
      checks++;
      if (sideError !== 1'b0) begin
        errors++;
        $display("FAIL reset_sideError cycle %0d: got %b expected 0", c, sideError);
      end
`endif
      sendAddOrderWithMPID = 1'($urandom());
    end
    rst                  = 1'b0;
    sendAddOrderWithMPID = 1'b0;
    dataReady            = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    set_fields_a(8'h42);
    dataReady = 1'b1;
    start_msg();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (dataOut !== EXP_A[i]) begin
        errors++;
        $display("FAIL basic_w%0d dataOut: got %h expected %h", i, dataOut, EXP_A[i]);
      end
      checks++;
      if ({dataValid, busy, dataLast, dataKeep, wordIndex} !==
          {1'b1, 1'b1, (i == 5), (i == 5) ? 8'h3F : 8'hFF, 3'(i)}) begin
        errors++;
        $display("FAIL basic_w%0d flags: got valid=%b busy=%b last=%b keep=%h idx=%0d expected 1 1 %b %h %0d",
                 i, dataValid, busy, dataLast, dataKeep, wordIndex, (i == 5),
                 (i == 5) ? 8'h3F : 8'hFF, i);
      end
    end
    @(negedge clk);
    checks++;
    if ({dataValid, busy, dataOut, dataKeep, wordIndex} !== 77'd0) begin
      errors++;
      $display("FAIL basic_idle_after: got valid=%b busy=%b data=%h keep=%h idx=%0d expected all 0",
               dataValid, busy, dataOut, dataKeep, wordIndex);
    end
  endtask

  task automatic test_backpressure();
    int vcnt;
    vcnt = 0;
    set_fields_a(8'h42);
    dataReady = 1'b1;
    start_msg();
    for (int c = 0; c < 12; c++) begin
      if (dataValid === 1'b1) vcnt++;
      if (c >= 2 && c <= 5) begin
        checks++;
        if (dataOut !== EXP_A[2] || wordIndex !== 3'd2 || dataKeep !== 8'hFF || dataLast !== 1'b0) begin
          errors++;
          $display("FAIL bp_hold cycle %0d: got data=%h idx=%0d keep=%h last=%b expected %h 2 ff 0",
                   c, dataOut, wordIndex, dataKeep, dataLast, EXP_A[2]);
        end
      end
      if (c == 8) begin
        checks++;
        if (dataOut !== EXP_A[5] || dataLast !== 1'b1 || dataKeep !== 8'h3F) begin
          errors++;
          $display("FAIL bp_last: got data=%h last=%b keep=%h expected %h 1 3f",
                   dataOut, dataLast, dataKeep, EXP_A[5]);
        end
      end
      if (c == 2) dataReady = 1'b0;
      if (c == 5) dataReady = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (vcnt != 9) begin
      errors++;
      $display("FAIL bp_cycles: got %0d valid cycles expected 9", vcnt);
    end
  endtask

  task automatic test_busy_ignore();
    set_fields_a(8'h42);
    dataReady = 1'b1;
    start_msg();
    for (int c = 0; c < 14; c++) begin
      if (c <= 5) begin
        checks++;
        if (dataOut !== EXP_A[c] || wordIndex !== 3'(c) || dataValid !== 1'b1) begin
          errors++;
          $display("FAIL busy_ign_a_w%0d: got data=%h idx=%0d valid=%b expected %h %0d 1",
                   c, dataOut, wordIndex, dataValid, EXP_A[c], c);
        end
      end else if (c == 6 || c == 13) begin
        checks++;
        if (dataValid !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_ign_idle cycle %0d: got valid=%b busy=%b expected 0 0", c, dataValid, busy);
        end
      end else begin
        checks++;
        if (dataOut !== EXP_B[c-7] || wordIndex !== 3'(c-7) || dataValid !== 1'b1) begin
          errors++;
          $display("FAIL busy_ign_b_w%0d: got data=%h idx=%0d valid=%b expected %h %0d 1",
                   c - 7, dataOut, wordIndex, dataValid, EXP_B[c-7], c - 7);
        end
      end
      // Request held from word 3 through the w5 handshake into the first idle cycle
      if (c == 3) begin
        set_fields_b();
        sendAddOrderWithMPID = 1'b1;
      end
      if (c == 7) sendAddOrderWithMPID = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    set_fields_a(8'h42);
    dataReady = 1'b1;
    start_msg();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (wordIndex !== 3'd2) begin
      errors++;
      $display("FAIL rstmid_pre: got idx=%0d expected 2", wordIndex);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({dataValid, busy, dataOut, wordIndex, dataLast, dataKeep} !== 78'd0) begin
      errors++;
      $display("FAIL rstmid_clear: got valid=%b busy=%b data=%h idx=%0d last=%b keep=%h expected all 0",
               dataValid, busy, dataOut, wordIndex, dataLast, dataKeep);
    end
    set_fields_b();
    start_msg();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (dataOut !== EXP_B[i] || wordIndex !== 3'(i) || dataLast !== (i == 5)) begin
        errors++;
        $display("FAIL rstmid_b_w%0d: got data=%h idx=%0d last=%b expected %h %0d %b",
                 i, dataOut, wordIndex, dataLast, EXP_B[i], i, (i == 5));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_side();
    set_fields_a(8'h58);
    dataReady = 1'b1;
    start_msg();
`ifdef ITCH_ADD_MPID_SIDE_CHECK_EN
    checks++;
    if (sideError !== 1'b1 || dataValid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL side_pulse: got err=%b valid=%b busy=%b expected 1 0 0", sideError, dataValid, busy);
    end
    @(negedge clk);
    checks++;
    if (sideError !== 1'b0 || dataValid !== 1'b0) begin
      errors++;
      $display("FAIL side_after: got err=%b valid=%b expected 0 0", sideError, dataValid);
    end
`else
    begin
      logic [63:0] exp_w;
      for (int i = 0; i < 6; i++) begin
        if (i > 0) @(negedge clk);
        exp_w = (i == 2) ? 64'h0000000758AABBCC : EXP_A[i];
        checks++;
        if (dataOut !== exp_w || dataValid !== 1'b1) begin
          errors++;
          $display("FAIL side_w%0d: got data=%h valid=%b expected %h 1", i, dataOut, dataValid, exp_w);
        end
      end
      @(negedge clk);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid();
    test_side();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/itch_add_order_mpid_tx.md
# itch_add_order_mpid_tx

Serializer for the ITCH Add Order with Participant ID message (type 0x46, 'F'). It captures a complete set of message fields in one cycle and emits the message as six 64-bit words on a valid/ready stream with backpressure, last-word and byte-keep flags. It is the transmit-side counterpart of the add-order-with-MPID field parser. It feeds the same 64-bit word bus used by the parsing chain and is used by the message generator and by loopback benches.

## Interface
Parameters: none.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- sendAddOrderWithMPID  in  1  start request; fields below are sampled when this is high and busy is low
- timeStamp  in  32  nanosecond timestamp
- orderID  in  64
- orderBookID  in  32
- side  in  8  ASCII 'B' (0x42) or 'S' (0x53)
- orderBookPosition  in  32
- quantity  in  64
- price  in  32
- orderAttributes  in  16
- lotType  in  8
- participantID  in  56
- busy  out  1  high from capture until the last word handshake completes
- dataOut  out  64  current message word
- dataValid  out  1  dataOut is valid
- dataReady  in  1  downstream accepts the word when dataValid and dataReady are both high
- dataLast  out  1  high with word 5
- dataKeep  out  8  byte-valid mask for dataOut
- wordIndex  out  3  index of the word on dataOut, 0..5
- sideError  out  1  one-cycle error pulse (present only with ITCH_ADD_MPID_SIDE_CHECK_EN)

## Operation
- States: IDLE, SEND. Reset forces IDLE.
- IDLE:
  - busy=0, dataValid=0, dataOut=0, dataLast=0, dataKeep=0, wordIndex=0.
  - On sendAddOrderWithMPID=1, register all fields into holding registers, then go to SEND with wordIndex=0.
- SEND:
  - dataValid=1 and dataOut=word[wordIndex].
  - On dataValid&&dataReady: if wordIndex<5, increment wordIndex; if wordIndex=5, go to IDLE.
  - sendAddOrderWithMPID is ignored. Holding registers do not change.
- Word layout, little-endian within the word:
  - w0: [7:0]=0x46, [23:8]=0, [55:24]=timeStamp, [63:56]=orderID[7:0]
  - w1: [55:0]=orderID[63:8], [63:56]=orderBookID[7:0]
  - w2: [23:0]=orderBookID[31:8], [31:24]=side, [63:32]=orderBookPosition
  - w3: [63:0]=quantity
  - w4: [31:0]=price, [47:32]=orderAttributes, [55:48]=lotType, [63:56]=participantID[7:0]
  - w5: [47:0]=participantID[55:8], [63:48]=0
- dataKeep:
  - 8'hFF for w0..w4; 8'h3F for w5.
  - dataLast=1 only while wordIndex=5 in SEND.
  - Message length is 46 bytes.
- Field values are copied bit-exact. No arithmetic and no range checks, except the side check under the configuration macro.

## Timing
- All outputs are registered or decoded from registered state only. There is no combinational path from dataReady or the field inputs to any output.
- Capture at edge N: busy=1 and dataValid=1 with w0 from edge N onward.
- With dataReady held high, w0..w5 appear on six consecutive cycles. busy and dataValid fall at the edge that accepts w5.
- Back-to-back messages: a start request is accepted in the first IDLE cycle after w5. Minimum period is 7 cycles per message.
- dataReady low stalls the stream. dataOut, dataKeep, dataLast and wordIndex hold stable while dataValid=1 and dataReady=0 (AXI-stream rule).
- A start request in the same cycle as the w5 handshake is ignored, because busy is still 1.
- rst mid-message: at the next edge, state becomes IDLE and all outputs go to 0. The partial message is abandoned and no further words are emitted. Holding registers are cleared to 0.

## Configuration
- ITCH_ADD_MPID_SIDE_CHECK_EN defined:
  - At capture, side must be 0x42 or 0x53.
  - If it is not, the request is dropped: the block stays in IDLE, busy stays 0, no words are emitted, and sideError pulses high for exactly one cycle after the edge.
- ITCH_ADD_MPID_SIDE_CHECK_EN undefined:
  - Any side value is serialized unchanged.
  - The sideError port is not present.

## Test plan
- Basic send: timeStamp=0x11223344, orderID=0x0102030405060708, orderBookID=0xAABBCCDD, side=0x42, orderBookPosition=7, quantity=1000, price=0x00989680, orderAttributes=0x0001, lotType=1, participantID=0x4D4D4D4D4D4D4D, dataReady=1.
  - Expect six words on consecutive cycles.
  - w0=0x0811223344000046.
  - w5=0x00004D4D4D4D4D4D with dataKeep=0x3F and dataLast=1.
- Backpressure: same message, dataReady low for 3 cycles at w2.
  - w2 is held stable for those cycles and wordIndex stays 2.
  - The stream completes in 9 cycles total.
- Busy ignore: a second start with different fields while wordIndex=3.
  - The output is still the first message.
  - A start in the first IDLE cycle sends the second message starting with w0.
- Reset mid-message: rst=1 while wordIndex=2.
  - Next cycle: dataValid=0, busy=0, dataOut=0, wordIndex=0.
  - A subsequent start sends a full message.
- Side check (macro defined): side=0x58.
  - sideError pulses for 1 cycle and dataValid stays 0.
  - Without the macro, w2[31:24]=0x58 is emitted.
- Reset values: hold rst for 2 cycles with random inputs.
  - All outputs are 0 throughout.
